mbist_resp_analyzer: RTL

- Parametrised, pipelined successor to the MBIST comparator: compares expected pattern data against RAM read data each strobed cycle.
- Adds a per-bit compare mask, an optional signed mode, a sticky fail flag, a saturating fail counter and first-fail capture.
- Keeps a show-ahead miscompare log FIFO that the BIST controller or a debug port drains.
- Sits between the MBIST pattern engine and the RAM read port.

---
 rtl/mbist_resp_analyzer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mbist_resp_analyzer.sv
// MBIST response analyzer: one-stage masked compare with sticky fail,
// saturating fail count, first-fail capture and a show-ahead miscompare log.
module mbist_resp_analyzer #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 10,
    parameter int LOG_DEPTH  = 4,
    parameter int CNT_W      = 8,
    parameter int SIGNED_CMP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              cmp_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_t,
    input  logic [DATA_W-1:0] ramout,
    input  logic [DATA_W-1:0] cmp_mask,
    output logic              cmp_valid,
    output logic              gt,
    output logic              eq,
    output logic              lt,
    output logic              fail,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [ADDR_W-1:0] first_addr,
    output logic [DATA_W-1:0] first_exp,
    output logic [DATA_W-1:0] first_act,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [ADDR_W-1:0] log_addr,
    output logic [DATA_W-1:0] log_exp,
    output logic [DATA_W-1:0] log_act,
    output logic              log_ovf
);
    localparam int PTR_W = $clog2(LOG_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp;
        logic [DATA_W-1:0] act;
    } log_entry_t;

    logic [DATA_W-1:0]   exp_m, act_m;
    logic signed [DATA_W:0] exp_x, act_x;
    logic                in_gt, in_eq, in_lt;

    logic [ADDR_W-1:0]   s1_addr;
    logic [DATA_W-1:0]   s1_exp, s1_act;

    log_entry_t          log_mem [LOG_DEPTH];
    log_entry_t          log_head;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [OCC_W-1:0]    log_count;
    logic                miscmp, log_full, push, pop, drop;

    // Extending by one bit lets a single signed comparator serve both modes:
    // the extra bit is the sign copy when signed, zero when unsigned.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        exp_m = data_t & cmp_mask;
        act_m = ramout & cmp_mask;
        exp_x = {(SIGNED_CMP != 0) & exp_m[DATA_W-1], exp_m};
        act_x = {(SIGNED_CMP != 0) & act_m[DATA_W-1], act_m};
        in_eq = (exp_m == act_m);
        in_gt = (exp_x > act_x);
        in_lt = ~in_gt & ~in_eq;
    end

    always_comb begin
        miscmp    = cmp_valid & ~eq;
        log_valid = (log_count != '0);
        log_full  = (log_count == OCC_W'(LOG_DEPTH));
        pop       = log_valid & log_ready;
        push      = miscmp & (~log_full | pop);
        drop      = miscmp & log_full & ~pop;
        log_head  = log_mem[rd_ptr];
        log_addr  = log_valid ? log_head.addr : '0;
        log_exp   = log_valid ? log_head.exp  : '0;
        log_act   = log_valid ? log_head.act  : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_valid  <= 1'b0;
            gt         <= 1'b0;
            eq         <= 1'b0;
            lt         <= 1'b0;
            s1_addr    <= '0;
            s1_exp     <= '0;
            s1_act     <= '0;
            fail       <= 1'b0;
            fail_cnt   <= '0;
            first_addr <= '0;
            first_exp  <= '0;
            first_act  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            log_count  <= '0;
            log_ovf    <= 1'b0;
        end else if (clear) begin
            cmp_valid  <= 1'b0;
            gt         <= 1'b0;
            eq         <= 1'b0;
            lt         <= 1'b0;
            s1_addr    <= '0;
            s1_exp     <= '0;
            s1_act     <= '0;
            fail       <= 1'b0;
            fail_cnt   <= '0;
            first_addr <= '0;
            first_exp  <= '0;
            first_act  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            log_count  <= '0;
            log_ovf    <= 1'b0;
        end else begin
            cmp_valid <= cmp_en;
            gt        <= cmp_en & in_gt;
            eq        <= cmp_en & in_eq;
            lt        <= cmp_en & in_lt;
            if (cmp_en) begin
                s1_addr <= addr;
                s1_exp  <= exp_m;
                s1_act  <= act_m;
            end
            if (miscmp) begin
                fail <= 1'b1;
                if (fail_cnt != '1)
                    fail_cnt <= fail_cnt + CNT_W'(1);
                if (!fail) begin
                    first_addr <= s1_addr;
                    first_exp  <= s1_exp;
                    first_act  <= s1_act;
                end
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            log_count <= log_count + OCC_W'(push) - OCC_W'(pop);
            if (drop)
                log_ovf <= 1'b1;
        end
    end

    // NOTE: log storage is not reset; emptiness lives in the pointers and head outputs are gated by log_valid.
    always_ff @(posedge clk) begin
        if (push && !clear)
            log_mem[wr_ptr] <= '{addr: s1_addr, exp: s1_exp, act: s1_act};
    end

endmodule
